mod_counter_chain: RTL and testbench

Parametrised multi-digit modulo-N counter, the successor to the single mod-10 digit counter with carry-out. It provides DIGITS cascaded digits, each DIGIT_W bits wide, counting modulo MODULUS, with enable, up/down direction, synchronous clear and parallel load. It is used for decimal event/cycle counters, timers and display counters in the CPU test and peripheral area.

---
 rtl/counter_pkg.sv | 17 +
 rtl/mod_digit.sv | 48 ++++
 rtl/mod_counter_chain.sv | 84 ++++++++
 tb/tb_mod_counter_chain.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared helpers for the modulo digit counter chain: terminal value,
// parameter legality check and digit packing offset.
package counter_pkg;

  function automatic int unsigned term_val(input int unsigned modulus, input logic up);
    return up ? modulus - 1 : 0;
  endfunction

  function automatic bit modulus_ok(input int modulus, input int digit_w);
    return (digit_w >= 1) && (digit_w < 31) && (modulus >= 2) && (modulus <= (1 << digit_w));
  endfunction

  function automatic int digit_off(input int idx, input int digit_w);
    return idx * digit_w;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// One DIGIT_W-bit modulo-MODULUS digit: clr > load > step, up/down with wrap.
module mod_digit
  import counter_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               step,
  input  logic               up,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               tc
);

  localparam logic [DIGIT_W-1:0] MAX   = DIGIT_W'(term_val(MODULUS, 1'b1));
  localparam logic [DIGIT_W:0]   MOD_X = (DIGIT_W+1)'(MODULUS);

  logic [DIGIT_W-1:0] digit_d, digit_q, term;
  logic               in_range;

  always_comb begin
    term     = up ? MAX : '0;
    in_range = {1'b0, load_val} < MOD_X;
    digit_d  = digit_q;
    if (clr)
      digit_d = '0;
    else if (load)
      digit_d = in_range ? load_val : '0;
    else if (step) begin
      if (digit_q == term)
        digit_d = up ? '0 : MAX;
      else
        digit_d = up ? digit_q + DIGIT_W'(1) : digit_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) digit_q <= '0;
    else       digit_q <= digit_d;

  assign digit = digit_q;
  assign tc    = (digit_q == term);

endmodule

// File: rtl/mod_counter_chain.sv
// Cascaded modulo-N digit counter with tc ripple chain, load range error pulse
// and optional sticky wrap flag (enabled by COUNTER_OVF_STICKY_EN).
module mod_counter_chain
  import counter_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  parameter int MODULUS = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      up,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
  output logic [DIGITS*DIGIT_W-1:0] cnt,
  output logic                      tc,
  output logic                      cout,
  output logic                      load_err,
  output logic                      ovf
);

  if (!modulus_ok(MODULUS, DIGIT_W) || DIGITS < 1) begin : g_bad_param
    $error("mod_counter_chain: illegal DIGITS/DIGIT_W/MODULUS");
  end

  localparam logic [DIGIT_W:0] MOD_X = (DIGIT_W+1)'(MODULUS);

  logic [DIGITS-1:0] tc_vec, step, bad;
  logic              load_err_d, load_err_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    localparam int OFF = digit_off(i, DIGIT_W);

    // A digit advances only when every lower digit is at its terminal value.
    if (i == 0) begin : g_first
      assign step[i] = en;
    end else begin : g_rest
      assign step[i] = step[i-1] & tc_vec[i-1];
    end

    assign bad[i] = {1'b0, load_val[OFF +: DIGIT_W]} >= MOD_X;

    mod_digit #(.DIGIT_W(DIGIT_W), .MODULUS(MODULUS)) u_digit (
      .clk      (clk),
      .rstn     (rstn),
      .step     (step[i]),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[OFF +: DIGIT_W]),
      .digit    (cnt[OFF +: DIGIT_W]),
      .tc       (tc_vec[i])
    );
  end

  assign tc   = &tc_vec;
  assign cout = en & tc;

  always_comb load_err_d = load & ~clr & (|bad);

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) load_err_q <= 1'b0;
    else       load_err_q <= load_err_d;

  assign load_err = load_err_q;

`ifdef COUNTER_OVF_STICKY_EN
  logic ovf_d, ovf_q;

  // A full-chain wrap only happens in a pure counting cycle.
  always_comb ovf_d = clr ? 1'b0 : (ovf_q | (cout & ~load));

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed, scoreboard-based bench for mod_counter_chain (default 4x BCD digits
// plus a DIGITS=2, DIGIT_W=3, MODULUS=6 instance).
module tb_mod_counter_chain;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en, up, clr, load;
  logic [15:0] load_val, cnt;
  logic        tc, cout, load_err, ovf;

  logic        en2, up2, clr2, load2;
  logic [5:0]  load_val2, cnt2;
  logic        tc2, cout2, load_err2, ovf2;

  always #5 clk = ~clk;

  mod_counter_chain u_dut (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt), .tc(tc), .cout(cout),
    .load_err(load_err), .ovf(ovf)
  );

  mod_counter_chain #(.DIGITS(2), .DIGIT_W(3), .MODULUS(6)) u_dut2 (
    .clk(clk), .rstn(rstn), .en(en2), .up(up2), .clr(clr2), .load(load2),
    .load_val(load_val2), .cnt(cnt2), .tc(tc2), .cout(cout2),
    .load_err(load_err2), .ovf(ovf2)
  );

  typedef struct {
    logic [15:0] cnt;
    logic        lerr;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  logic [5:0]  q2[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  int          m_v;
  logic        m_ovf;

  // Model keeps the count as a plain integer and converts to packed digits.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int san(input logic [15:0] lv);
    int r, mul;
    r = 0;
    mul = 1;
    for (int i = 0; i < 4; i++) begin
      if (lv[i*4 +: 4] < 4'd10) r += int'(lv[i*4 +: 4]) * mul;
      mul *= 10;
    end
    return r;
  endfunction

  function automatic logic any_bad(input logic [15:0] lv);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) if (lv[i*4 +: 4] >= 4'd10) b = 1'b1;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic en_i, input logic up_i, input logic clr_i,
                       input logic ld_i, input logic [15:0] lv_i);
    exp_t e;
    logic tc_e;
    en = en_i; up = up_i; clr = clr_i; load = ld_i; load_val = lv_i;
    #1;
    tc_e = up_i ? (m_v == 9999) : (m_v == 0);
    chk("tc", 32'(tc), 32'(tc_e));
    chk("cout", 32'(cout), 32'(en_i & tc_e));
    if (clr_i) begin
      m_v = 0; m_ovf = 1'b0; e.lerr = 1'b0;
    end else if (ld_i) begin
      m_v = san(lv_i); e.lerr = any_bad(lv_i);
    end else begin
      e.lerr = 1'b0;
      if (en_i) begin
`ifdef COUNTER_OVF_STICKY_EN
        if (tc_e) m_ovf = 1'b1;
`endif
        m_v = up_i ? (m_v + 1) % 10000 : (m_v + 9999) % 10000;
      end
    end
    e.cnt = to_bcd(m_v);
    e.ovf = m_ovf;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("cnt", 32'(cnt), 32'(e.cnt));
    chk("load_err", 32'(load_err), 32'(e.lerr));
    chk("ovf", 32'(ovf), 32'(e.ovf));
  endtask

  initial begin
    int v2;
    rstn = 1'b0;
    en = 0; up = 1; clr = 0; load = 0; load_val = '0;
    en2 = 0; up2 = 1; clr2 = 0; load2 = 0; load_val2 = '0;
    m_v = 0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_cnt2", 32'(cnt2), 32'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Count up 10 -> 0x0010
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 16'h0);
    chk("cnt_after_10", 32'(cnt), 32'h0010);

    // Full-chain wrap up
    drive(0, 1, 0, 1, 16'h9998);
    drive(1, 1, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 16'h0);

    // Count down through zero
    drive(0, 0, 0, 1, 16'h0001);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 16'h0);

    // Direction reversal mid-count
    drive(1, 1, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 16'h0);

    // Load range checks
    drive(1, 1, 0, 1, 16'h12A4);
    drive(0, 1, 0, 0, 16'h0);
    drive(0, 1, 0, 1, 16'h1234);
    drive(0, 1, 0, 0, 16'h0);
    drive(0, 1, 0, 1, 16'hFFFF);

    // Priority: clr beats load and en
    drive(0, 1, 0, 1, 16'h5555);
    drive(1, 1, 1, 1, 16'h9999);
    drive(0, 1, 0, 1, 16'h5555);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 16'h0);

    // Async reset mid-count
    drive(0, 1, 0, 1, 16'h0346);
    drive(1, 1, 0, 0, 16'h0);
    chk("pre_rst_cnt", 32'(cnt), 32'h0347);
    en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'h0);
    chk("async_rst_ovf", 32'(ovf), 32'h0);
    m_v = 0; m_ovf = 1'b0;
    @(negedge clk) rstn = 1'b1;
    drive(1, 1, 0, 0, 16'h0);
    chk("restart_cnt", 32'(cnt), 32'h0001);

    // Parameter sweep instance: 36 states, wraps on step 36
    en = 0;
    v2 = 0;
    for (int s = 0; s < 36; s++) begin
      logic [5:0] e2;
      en2 = 1'b1; up2 = 1'b1;
      #1;
      chk("cout2", 32'(cout2), 32'(v2 == 35));
      v2 = (v2 + 1) % 36;
      q2.push_back({3'(v2 / 6), 3'(v2 % 6)});
      @(posedge clk); #1;
      e2 = q2.pop_front();
      chk("cnt2", 32'(cnt2), 32'(e2));
    end
    en2 = 1'b0;
    chk("cnt2_wrapped", 32'(cnt2), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
